// File: rtl/outstanding_txn_tracker.sv
// Outstanding AXI transaction tracker: counts in-flight transactions, throttles
// new starts at MAX_OUTSTANDING and flags underflow and stall-watchdog faults.
module outstanding_txn_tracker #(
    parameter int unsigned MAX_OUTSTANDING = 4,
    parameter int unsigned TIMEOUT         = 256,
    localparam int unsigned CNT_W          = $clog2(MAX_OUTSTANDING + 1)
) (
    input  logic             ACLK,
    input  logic             ARESET,
    input  logic             start_valid,
    output logic             start_ready,
    input  logic             done_pulse,
    input  logic             clear_err,
    output logic [CNT_W-1:0] count,
    output logic             busy,
    output logic             full,
    output logic             underflow_err,
    output logic             timeout_err
);

    // A zero-width timer is illegal; keep one bit that is simply held at 0.
    localparam int unsigned TMR_W = (TIMEOUT == 0) ? 1 : $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {
        StIdle    = 2'd0,
        StActive  = 2'd1,
        StStalled = 2'd2
    } state_e;

    state_e           state_q, state_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic [TMR_W-1:0] timer_q, timer_d;
    logic             underflow_q, underflow_d;
    logic             timeout_q, timeout_d;

    logic accept;
    logic progress;
    logic cnt_zero;
    logic underflow_set;
    logic timeout_set;

    // Status outputs derive from the registered count only (no done bypass).
    always_comb begin
        cnt_zero    = (count_q == '0);
        full        = (count_q == CNT_W'(MAX_OUTSTANDING));
        busy        = !cnt_zero;
        start_ready = !full;
        count       = count_q;
    end

    // Next count and error-set conditions.
    always_comb begin
        accept        = start_valid && start_ready;
        progress      = accept || done_pulse;
        underflow_set = done_pulse && cnt_zero;
        count_d       = count_q;
        if (accept && !(done_pulse && !cnt_zero)) begin
            count_d = count_q + CNT_W'(1);
        end else if (!accept && done_pulse && !cnt_zero) begin
            count_d = count_q - CNT_W'(1);
        end
    end

    // Stall watchdog: runs only while work is outstanding and nothing moves.
    always_comb begin
        timer_d     = '0;
        timeout_set = 1'b0;
        if (TIMEOUT != 0 && !progress && !cnt_zero) begin
            if (timer_q < TMR_W'(TIMEOUT)) begin
                timer_d     = timer_q + TMR_W'(1);
                timeout_set = (timer_d == TMR_W'(TIMEOUT));
            end else begin
                timer_d = timer_q;
            end
        end
    end

    // Sticky error flags; a new error on the clearing edge wins.
    always_comb begin
        underflow_d = (underflow_q && !clear_err) || underflow_set;
        timeout_d   = (timeout_q && !clear_err) || timeout_set;
    end

    // State machine next-state logic.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle: begin
                if (accept) state_d = StActive;
            end
            StActive: begin
                if (count_d == '0)    state_d = StIdle;
                else if (timeout_set) state_d = StStalled;
            end
            StStalled: begin
                if (progress) state_d = (count_d == '0) ? StIdle : StActive;
            end
            default: state_d = StIdle;
        endcase
    end

    // State registers with asynchronous reset.
    always_ff @(posedge ACLK or posedge ARESET) begin
        if (ARESET) begin
            state_q     <= StIdle;
            count_q     <= '0;
            timer_q     <= '0;
            underflow_q <= 1'b0;
            timeout_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            count_q     <= count_d;
            timer_q     <= timer_d;
            underflow_q <= underflow_d;
            timeout_q   <= timeout_d;
        end
    end

    assign underflow_err = underflow_q;
    assign timeout_err   = timeout_q;

endmodule

// File: tb/tb_outstanding_txn_tracker.sv
// Directed self-checking bench for outstanding_txn_tracker.
module tb_outstanding_txn_tracker;

    logic       ACLK = 1'b0;
    logic       ARESET;
    logic       start_valid, done_pulse, clear_err;
    logic       start_ready, busy, full, underflow_err, timeout_err;
    logic [2:0] count;
    logic       nt_start_ready, nt_busy, nt_full, nt_underflow_err, nt_timeout_err;
    logic [2:0] nt_count;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 ACLK = ~ACLK;

    outstanding_txn_tracker #(.MAX_OUTSTANDING(4), .TIMEOUT(8)) dut (
        .ACLK(ACLK), .ARESET(ARESET), .start_valid(start_valid), .start_ready(start_ready),
        .done_pulse(done_pulse), .clear_err(clear_err), .count(count), .busy(busy),
        .full(full), .underflow_err(underflow_err), .timeout_err(timeout_err)
    );

    // Watchdog disabled instance sharing the same stimulus.
    outstanding_txn_tracker #(.MAX_OUTSTANDING(4), .TIMEOUT(0)) dut_nt (
        .ACLK(ACLK), .ARESET(ARESET), .start_valid(start_valid), .start_ready(nt_start_ready),
        .done_pulse(done_pulse), .clear_err(clear_err), .count(nt_count), .busy(nt_busy),
        .full(nt_full), .underflow_err(nt_underflow_err), .timeout_err(nt_timeout_err)
    );

    task automatic check(input string tag, input int unsigned got, input int unsigned exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Advance one edge, then sample 1 time unit later.
    task automatic tick(input logic sv, input logic dp, input logic ce);
        start_valid = sv;
        done_pulse  = dp;
        clear_err   = ce;
        @(posedge ACLK);
        #1;
        start_valid = 1'b0;
        done_pulse  = 1'b0;
        clear_err   = 1'b0;
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, "_count"}, count, 0);
        check({tag, "_busy"}, busy, 0);
        check({tag, "_full"}, full, 0);
        check({tag, "_ready"}, start_ready, 1);
        check({tag, "_uflow"}, underflow_err, 0);
        check({tag, "_tout"}, timeout_err, 0);
        check({tag, "_state"}, int'(dut.state_q), 0);
        check({tag, "_timer"}, dut.timer_q, 0);
    endtask

    initial begin
        ARESET      = 1'b1;
        start_valid = 1'b0;
        done_pulse  = 1'b0;
        clear_err   = 1'b0;
        #3;
        check_reset_vals("rst");
        @(negedge ACLK);
        ARESET = 1'b0;

        // Fill to MAX with consecutive accepts.
        for (int i = 1; i <= 4; i++) begin
            tick(1, 0, 0);
            check($sformatf("fill_count%0d", i), count, i);
        end
        check("fill_full", full, 1);
        check("fill_ready", start_ready, 0);
        check("fill_busy", busy, 1);
        tick(1, 0, 0);
        check("fifth_rejected", count, 4);

        // Done at full with start_valid: no accept, slot freed next cycle.
        tick(1, 1, 0);
        check("full_done_count", count, 3);
        check("full_done_ready", start_ready, 1);
        tick(1, 0, 0);
        check("refill_count", count, 4);

        // Down to 2, let timer run, then simultaneous accept+done.
        tick(0, 1, 0);
        tick(0, 1, 0);
        check("down_count", count, 2);
        tick(0, 0, 0);
        tick(0, 0, 0);
        tick(0, 0, 0);
        check("timer_runs", dut.timer_q, 3);
        tick(1, 1, 0);
        check("both_count", count, 2);
        check("both_timer", dut.timer_q, 0);

        // Drain, then underflow.
        tick(0, 1, 0);
        tick(0, 1, 0);
        check("drain_count", count, 0);
        check("drain_state", int'(dut.state_q), 0);
        tick(0, 1, 0);
        check("uflow_set", underflow_err, 1);
        check("uflow_count", count, 0);
        tick(0, 0, 1);
        check("uflow_clear", underflow_err, 0);
        tick(0, 1, 1);
        check("uflow_set_wins", underflow_err, 1);
        tick(0, 0, 1);
        check("uflow_clear2", underflow_err, 0);
        tick(1, 1, 0);
        check("uflow_accept_count", count, 1);
        check("uflow_accept_flag", underflow_err, 1);
        tick(0, 1, 1);
        check("uflow_accept_drain", count, 0);
        check("uflow_accept_clr", underflow_err, 0);

        // Watchdog: accept at E0, then idle.
        tick(1, 0, 0);
        for (int i = 1; i <= 7; i++) tick(0, 0, 0);
        check("wd_e7_err", timeout_err, 0);
        check("wd_e7_state", int'(dut.state_q), 1);
        tick(0, 0, 0);
        check("wd_e8_err", timeout_err, 1);
        check("wd_e8_state", int'(dut.state_q), 2);
        check("wd_ready_stalled", start_ready, 1);
        tick(0, 1, 0);
        check("wd_done_count", count, 0);
        check("wd_done_state", int'(dut.state_q), 0);
        check("wd_sticky", timeout_err, 1);
        tick(0, 0, 0);
        tick(0, 0, 0);
        check("wd_sticky2", timeout_err, 1);
        tick(0, 0, 1);
        check("wd_clear", timeout_err, 0);

        // Disabled watchdog: one accept, idle 1000 cycles.
        tick(1, 0, 0);
        check("nt_count", nt_count, 1);
        for (int i = 0; i < 1000; i++) tick(0, 0, 0);
        check("nt_no_timeout", nt_timeout_err, 0);
        check("nt_timer", dut_nt.timer_q, 0);
        check("nt_ref_timeout", timeout_err, 1);
        tick(0, 1, 1);
        check("nt_drain", nt_count, 0);
        check("nt_clear", timeout_err, 0);

        // Async reset mid-cycle with count 3 and underflow set.
        tick(0, 1, 0);
        tick(1, 0, 0);
        tick(1, 0, 0);
        tick(1, 0, 0);
        check("pre_rst_count", count, 3);
        check("pre_rst_uflow", underflow_err, 1);
        #1;
        ARESET = 1'b1;
        #1;
        check_reset_vals("async_rst");
        #1;
        ARESET = 1'b0;
        tick(1, 0, 0);
        check("post_rst_count", count, 1);
        tick(1, 0, 0);
        check("post_rst_count2", count, 2);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/outstanding_txn_tracker.md
# outstanding_txn_tracker

Counts in-flight AXI transactions for one master port. Directly consumes the one-cycle completion pulse from the interconnect's falling-edge detector, which fires when a channel's busy signal drops. Throttles new transaction starts at a configurable depth and flags protocol faults: a completion with nothing outstanding, or no progress for too long. Sits between the master-side address handshake logic and the arbiter's grant gating.

## Interface
- MAX_OUTSTANDING, 4: maximum in-flight transactions; legal range 1..255.
- TIMEOUT, 256: stall-watchdog threshold in cycles; 0 disables the watchdog.
- CNT_W, $clog2(MAX_OUTSTANDING+1): width of count (derived localparam, not overridable).
- ACLK  in  1  clock; all state updates on rising edge.
- ARESET  in  1  reset: asynchronous, active-high.
- start_valid  in  1  a new transaction requests issue.
- start_ready  out  1  tracker can accept a new transaction.
- done_pulse  in  1  one-cycle completion pulse from the falling-edge detector.
- clear_err  in  1  clears sticky error flags.
- count  out  CNT_W  current outstanding transactions.
- busy  out  1  count != 0.
- full  out  1  count == MAX_OUTSTANDING.
- underflow_err  out  1  sticky: done_pulse arrived while count == 0.
- timeout_err  out  1  sticky: watchdog expired.

## Operation
- Start accepted on an edge where start_valid && start_ready.
- start_ready = !full. It is combinational from registered count only, with no same-cycle bypass from done_pulse.
- Count update per edge:
  - accept only: +1.
  - done only with count > 0: -1.
  - accept and done together: unchanged.
  - done with count == 0 (cannot coincide with a legal decrement): count stays 0 and underflow_err sets. If an accept happens on the same edge, count becomes 1 and underflow_err still sets.
- Watchdog timer, width $clog2(TIMEOUT+1):
  - cleared on any edge with a progress event (accept or done) or when count == 0.
  - otherwise increments by 1 per cycle and saturates at TIMEOUT.
- timeout_err sets on the edge at which the timer reaches TIMEOUT.
- With TIMEOUT == 0 the timer is held at 0 and timeout_err never sets.
- State machine, state_q:
  - IDLE (count == 0) -> ACTIVE on accept.
  - ACTIVE -> IDLE when count goes to 0.
  - ACTIVE -> STALLED when timeout_err sets.
  - STALLED -> ACTIVE or IDLE (matching the new count) on any progress event.
  - STALLED does not block starts. Counting continues normally in every state.
- clear_err clears both sticky flags at the next edge. If an error condition occurs on the same edge as clear_err, the flag sets; set wins over clear.
- Errors do not block operation.

## Timing
- Reset values: count = 0, busy = 0, full = 0, start_ready = 1, underflow_err = 0, timeout_err = 0, timer = 0, state IDLE.
- ARESET assertion mid-operation clears everything immediately, with no clock needed. In-flight transactions are forgotten.
- Latency: count, busy and full reflect an event one edge after it is sampled.
- start_ready drops in the same cycle count reaches MAX_OUTSTANDING, i.e. after the edge that filled it.
- A done_pulse in a full cycle frees a slot only from the next cycle on.
- done_pulse already lags the falling busy signal by one cycle. The tracker adds no further delay, so the total is 2 cycles from the signal falling to count decrementing.
- Watchdog: if the last progress edge is E0 and count > 0 afterwards, timeout_err = 1 after edge E0+TIMEOUT, and not before.
- Wrap-around: count never exceeds MAX_OUTSTANDING and never goes below 0. The timer never wraps.

## Test plan
- Reset, then 4 accepts on consecutive cycles with MAX = 4 -> count 1, 2, 3, 4; full = 1 and start_ready = 0 after the 4th edge; a 5th start_valid is not accepted.
- Full (count 4), assert start_valid and done_pulse together -> no accept that cycle; count = 3 next cycle; accept on the following cycle -> count = 4.
- count = 2, simultaneous accept and done -> count stays 2 and the watchdog timer clears. done_pulse at count 0 -> underflow_err = 1 and count stays 0. clear_err -> underflow_err = 0 next edge.
- TIMEOUT = 8, one accept at edge E0, then idle -> timeout_err = 0 after E0+7 and 1 after E0+8; state STALLED. done_pulse -> count 0, state IDLE, timeout_err stays 1 until clear_err.
- TIMEOUT = 0, one accept, idle 1000 cycles -> timeout_err stays 0.
- count = 3 with underflow_err = 1, assert ARESET asynchronously mid-cycle -> all outputs take their reset values before the next edge; after release, accepts resume from count 0.
